// File: rtl/cv3_column_feeder_if.sv
// Filter-side bus of the cv3 column feeder.
// master (feeder): drives kernel_load, col_valid, input_column,
//                  kernel_column_0/1/2; receives filt_valid.
// slave  (filter): the mirror image.
interface cv3_column_feeder_if #(
   parameter int unsigned DATA_WIDTH     = 16,
   parameter int unsigned INPUT_COL_SIZE = 12
);
   logic                                 kernel_load;
   logic                                 col_valid;
   logic [INPUT_COL_SIZE*DATA_WIDTH-1:0] input_column;
   logic [DATA_WIDTH-1:0]                kernel_column_0;
   logic [DATA_WIDTH-1:0]                kernel_column_1;
   logic [DATA_WIDTH-1:0]                kernel_column_2;
   logic                                 filt_valid;

   modport master (
      output kernel_load, col_valid, input_column,
      output kernel_column_0, kernel_column_1, kernel_column_2,
      input  filt_valid
   );

   modport slave (
      input  kernel_load, col_valid, input_column,
      input  kernel_column_0, kernel_column_1, kernel_column_2,
      output filt_valid
   );
endinterface

// File: rtl/cv3_column_feeder.sv
// Transmit side of the cv3 column filter: loads one 3x3 kernel as three
// kernel_load columns, streams NUM_COLS image columns, then waits for the
// filter's valid results and reports done / err (drain timeout or excess).
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             job request, sampled only in IDLE
//   keep_kernel       (only with CV3_FEEDER_KEEP_KERNEL_EN) skip kernel load
//   busy/done/err     job status; err qualified by done
//   kern_rd_*         kernel memory read port, 1-cycle latency
//   img_rd_*          image column buffer read port, 1-cycle latency
//   filt              filter bus (master modport)
//
// Optional macro CV3_FEEDER_KEEP_KERNEL_EN adds keep_kernel.
module cv3_column_feeder #(
   parameter int unsigned DATA_WIDTH       = 16,
   parameter int unsigned KERNEL_SIZE      = 3,
   parameter int unsigned INPUT_COL_SIZE   = 12,
   parameter int unsigned NUM_COLS         = 12,
   parameter int unsigned EXPECTED_OUTPUTS = NUM_COLS - KERNEL_SIZE + 1,
   parameter int unsigned DRAIN_TIMEOUT    = 8
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  start,
`ifdef CV3_FEEDER_KEEP_KERNEL_EN
   input  logic                                  keep_kernel,
`endif
   output logic                                  busy,
   output logic                                  done,
   output logic                                  err,
   output logic                                  kern_rd_en,
   output logic [$clog2(KERNEL_SIZE)-1:0]        kern_rd_addr,
   input  logic [KERNEL_SIZE*DATA_WIDTH-1:0]     kern_rd_data,
   output logic                                  img_rd_en,
   output logic [$clog2(NUM_COLS)-1:0]           img_rd_addr,
   input  logic [INPUT_COL_SIZE*DATA_WIDTH-1:0]  img_rd_data,
   cv3_column_feeder_if.master                   filt
);

   localparam int unsigned KA_W  = $clog2(KERNEL_SIZE);
   localparam int unsigned CA_W  = $clog2(NUM_COLS);
   localparam int unsigned CNT_W = $clog2(EXPECTED_OUTPUTS + 2);
   localparam int unsigned TM_W  = $clog2(DRAIN_TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, LOAD_K, STREAM, DRAIN, FIN} state_t;

   state_t            state, state_n;
   logic [KA_W-1:0]   k_idx, k_idx_n;
   logic [CA_W-1:0]   c_idx, c_idx_n;
   logic [TM_W-1:0]   timer, timer_n;
   logic [CNT_W-1:0]  out_cnt, out_cnt_n;
   logic              kern_en_n, img_en_n, err_n;
   logic [KA_W-1:0]   kern_addr_n;
   logic [CA_W-1:0]   img_addr_n;
   logic              kernel_load_q, col_valid_q;
   logic              keep_k;

`ifdef CV3_FEEDER_KEEP_KERNEL_EN
   assign keep_k = keep_kernel;
`else
   assign keep_k = 1'b0;
`endif

   // Data buses pass straight through; they line up with the registered strobes.
   assign filt.input_column    = img_rd_data;
   assign filt.kernel_column_0 = kern_rd_data[0*DATA_WIDTH +: DATA_WIDTH];
   assign filt.kernel_column_1 = kern_rd_data[1*DATA_WIDTH +: DATA_WIDTH];
   assign filt.kernel_column_2 = kern_rd_data[2*DATA_WIDTH +: DATA_WIDTH];
   assign filt.kernel_load     = kernel_load_q;
   assign filt.col_valid       = col_valid_q;

   // State, counters and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         k_idx         <= '0;
         c_idx         <= '0;
         timer         <= '0;
         out_cnt       <= '0;
         kern_rd_en    <= 1'b0;
         kern_rd_addr  <= '0;
         img_rd_en     <= 1'b0;
         img_rd_addr   <= '0;
         kernel_load_q <= 1'b0;
         col_valid_q   <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
      end else begin
         state         <= state_n;
         k_idx         <= k_idx_n;
         c_idx         <= c_idx_n;
         timer         <= timer_n;
         out_cnt       <= out_cnt_n;
         kern_rd_en    <= kern_en_n;
         kern_rd_addr  <= kern_addr_n;
         img_rd_en     <= img_en_n;
         img_rd_addr   <= img_addr_n;
         kernel_load_q <= kern_rd_en;
         col_valid_q   <= kern_rd_en | img_rd_en;
         busy          <= (state_n == LOAD_K) || (state_n == STREAM) || (state_n == DRAIN);
         done          <= (state_n == FIN);
         err           <= err_n;
      end
   end

   // Next-state, read sequencing and result accounting.
   always_comb begin
      state_n     = state;
      k_idx_n     = k_idx;
      c_idx_n     = c_idx;
      timer_n     = timer;
      out_cnt_n   = out_cnt;
      kern_en_n   = 1'b0;
      kern_addr_n = kern_rd_addr;
      img_en_n    = 1'b0;
      img_addr_n  = img_rd_addr;
      err_n       = 1'b0;

      // Saturating count one above the target so excess results stay visible.
      if ((state != IDLE) && filt.filt_valid &&
          (out_cnt != CNT_W'(EXPECTED_OUTPUTS + 1)))
         out_cnt_n = out_cnt + 1'b1;

      case (state)
         IDLE: begin
            if (start) begin
               out_cnt_n = '0;
               k_idx_n   = '0;
               c_idx_n   = '0;
               state_n   = keep_k ? STREAM : LOAD_K;
            end
         end
         LOAD_K: begin
            kern_en_n   = 1'b1;
            kern_addr_n = k_idx;
            if (k_idx == KA_W'(KERNEL_SIZE - 1)) begin
               k_idx_n = '0;
               state_n = STREAM;
            end else begin
               k_idx_n = k_idx + 1'b1;
            end
         end
         STREAM: begin
            img_en_n   = 1'b1;
            img_addr_n = c_idx;
            if (c_idx == CA_W'(NUM_COLS - 1)) begin
               c_idx_n = '0;
               timer_n = '0;
               state_n = DRAIN;
            end else begin
               c_idx_n = c_idx + 1'b1;
            end
         end
         DRAIN: begin
            timer_n = timer + 1'b1;
            // Completion is checked before the timeout so a tie succeeds.
            if (out_cnt >= CNT_W'(EXPECTED_OUTPUTS)) begin
               state_n = FIN;
               err_n   = (out_cnt > CNT_W'(EXPECTED_OUTPUTS));
            end else if (timer_n == TM_W'(DRAIN_TIMEOUT)) begin
               state_n = FIN;
               err_n   = 1'b1;
            end
         end
         FIN:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: doc/cv3_column_feeder.md
Name: cv3_column_feeder

Overview:
- Transmit side of the cv3 column filter interface.
- On start, reads one 3x3 kernel from a kernel ROM/RAM and drives it as three kernel_load columns. Then reads NUM_COLS image columns from a column buffer and streams them as valid columns.
- Counts valid result columns returned by the filter and signals done, or an error on drain timeout.
- Sits between the layer's feature-map buffer and the cv3 filter bank.

Parameters:
- DATA_WIDTH, 16, element width (FP16 bit pattern, never interpreted).
- KERNEL_SIZE, 3, kernel height/width; number of kernel columns loaded.
- INPUT_COL_SIZE, 12, elements per image column.
- NUM_COLS, 12, image columns streamed per job.
- EXPECTED_OUTPUTS, NUM_COLS-KERNEL_SIZE+1, filter valid pulses expected per job.
- DRAIN_TIMEOUT, 8, cycles allowed after the last streamed column for outstanding outputs to arrive.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  job request; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at job end.
- err  out  1  valid with done; 1 = drain timeout or excess outputs.
- kern_rd_en  out  1  kernel memory read strobe.
- kern_rd_addr  out  $clog2(KERNEL_SIZE)  kernel column index.
- kern_rd_data  in  KERNEL_SIZE*DATA_WIDTH  kernel column; element r in bits [r*DATA_WIDTH +: DATA_WIDTH]; 1-cycle synchronous read latency.
- img_rd_en  out  1  image buffer read strobe.
- img_rd_addr  out  $clog2(NUM_COLS)  image column index.
- img_rd_data  in  INPUT_COL_SIZE*DATA_WIDTH  image column, same packing, 1-cycle latency.
- kernel_load  out  1  to filter kernel_load.
- col_valid  out  1  to filter valid_in.
- input_column  out  INPUT_COL_SIZE*DATA_WIDTH  to filter; driven from img_rd_data.
- kernel_column_0/1/2  out  DATA_WIDTH each  to filter; elements 0/1/2 of kern_rd_data.
- filt_valid  in  1  filter valid_out, counted.

Behaviour:
- Reset values: all outputs 0 except the pass-through data buses. State IDLE; all counters 0.
- FSM states: IDLE, LOAD_K, STREAM, DRAIN, FIN.
- IDLE: start=1 -> LOAD_K, out_cnt cleared. Start in any other state is ignored.
- LOAD_K: kern_rd_en=1 with kern_rd_addr 0..KERNEL_SIZE-1 on consecutive cycles. After addr KERNEL_SIZE-1 -> STREAM.
- STREAM: img_rd_en=1 with img_rd_addr 0..NUM_COLS-1 on consecutive cycles, no gaps. After addr NUM_COLS-1 -> DRAIN, timer cleared.
- Output timing: col_valid and kernel_load are the registered read strobes, one cycle after the read, aligned with returned data.
  - kernel_load = registered kern_rd_en.
  - col_valid = registered (kern_rd_en | img_rd_en).
- Timing example: start sampled at edge 0 gives kernel columns valid cycles 2..4 (kernel_load=1), then image columns cycles 5..NUM_COLS+4 (kernel_load=0). Kernel-to-image handoff is back-to-back.
- Data buses are undefined when col_valid=0. The filter ignores them.
- out_cnt increments on filt_valid in every state except IDLE. Saturates at EXPECTED_OUTPUTS+1.
- DRAIN: timer increments each cycle.
  - out_cnt==EXPECTED_OUTPUTS -> FIN with err=0.
  - Timer reaches DRAIN_TIMEOUT first -> FIN with err=1.
  - Both in the same cycle -> success wins.
- FIN: done=1 and err valid for one cycle, busy=0, -> IDLE. err also set if out_cnt>EXPECTED_OUTPUTS.
- busy=1 in LOAD_K, STREAM, DRAIN.
- Reset mid-job: immediate abort to IDLE. No done pulse; strobes drop asynchronously.
- start held high continuously: a new job starts the cycle after FIN, i.e. one idle cycle between jobs.

Optional Feature:
- Macro CV3_FEEDER_KEEP_KERNEL_EN.
- Defined: adds input keep_kernel (1 bit), sampled with start. keep_kernel=1 skips LOAD_K (IDLE -> STREAM directly), so no kernel_load columns are emitted and the previous filter weights are reused. Image columns are then valid starting cycle 2 after start.
- Not defined: port absent; kernel always reloaded.

Test Plan:
- Default params, one start; kernel memory returns col c = {c*3+2, c*3+1, c*3} -> kernel_load=1 with col_valid on exactly 3 cycles (2..4) carrying kernel_column_0 = 0, 3, 6. Then 12 col_valid cycles with kernel_load=0, img_rd_addr 0..11 in order. With the filter model returning 10 filt_valid pulses: done=1, err=0, busy low after.
- Filter model returns only 9 pulses -> done asserted exactly DRAIN_TIMEOUT=8 cycles after DRAIN entry, err=1.
- Filter model returns 11 pulses before the 10th count check -> done with err=1.
- start pulsed during STREAM -> ignored: exactly 12 image columns, single done.
- rst asserted in STREAM at column 5 -> col_valid/img_rd_en 0 immediately, busy=0, no done. Next start replays from kernel column 0.
- With CV3_FEEDER_KEEP_KERNEL_EN, start with keep_kernel=1 -> kernel_load never high, first col_valid 2 cycles after start, done/err as in scenario 1.
